lcd_rx_monitor: RTL
===================

Name: lcd_rx_monitor

Overview:
Receiving end of the 4-bit HD44780-style character LCD bus (LCD_E/RS/RW/D) that LCD_module drives.
- Decodes the bus into commands and character writes, and keeps a shadow DDRAM image of the two visible 16-char rows.
- Outputs the rows as 128-bit ASCII vectors, in the same packing as the row_A/row_B inputs of LCD_module.
- Used as an on-chip loopback checker (e.g. compare against the row_A/row_B driven into LCD_module) and as the bench-side LCD model.

Parameters:
BUSY_CMD, 4000, clk cycles a normal command/data write keeps the model busy (40 us at 100 MHz)
BUSY_CLR, 164000, clk cycles a clear/return-home keeps the model busy (1.64 ms)

Ports:
clk  input  1  system clock, 100 MHz
reset_n  input  1  asynchronous active-low reset
lcd_e  input  1  LCD enable; data latched on its falling edge
lcd_rs  input  1  register select: 0 = command, 1 = data
lcd_rw  input  1  1 = read cycle; this block never drives the bus
lcd_d  input  4  data nibble
row_a  output  128  top row; col 0 in bits [127:120]
row_b  output  128  bottom row, same packing
disp_on  output  1  display-control D bit
update  output  1  1-cycle pulse when row_a/row_b change
err  output  1  sticky: a write arrived while busy
four_bit  output  1  1 once the 4-bit interface mode is active

Behaviour:
- Reset values: row_a and row_b all 8'h20; disp_on=0; update=0; err=0; four_bit=0; addr=7'h00; increment=1; busy counter=0; state=MODE8.
- Input sampling: lcd_e, lcd_rs, lcd_rw and lcd_d each pass through a 2-flop synchroniser. The falling edge of lcd_e is detected on the synchronised signal.
  - RS, RW and D are taken from the synchronised values of the cycle before detection (E still high).
  - Bus requirement: RS/RW/D stable at least 3 clk either side of the E fall.
- Latency: a completed byte's effect on row_a/row_b/disp_on appears on the 4th clk edge after the lcd_e fall reaches the pad. update pulses in that same cycle.
- State machine:
  - MODE8: each E fall is one complete write whose upper nibble is lcd_d and lower nibble is 0. Only a function-set with DL=0 (nibble 4'h2, RS=0) moves the state to MODE4_HI and sets four_bit=1.
  - MODE4_HI: the E fall stores the high nibble and moves to MODE4_LO.
  - MODE4_LO: the E fall completes the byte, executes it, and returns to MODE4_HI.
  - RW=1 pulses advance the nibble phase like a write, but the byte is discarded and does not touch busy or err.
- Command decode, RS=0, highest set bit wins:
  - 1xxxxxxx: addr=byte[6:0]; CGRAM mode cleared.
  - 01xxxxxx: CGRAM mode; later data writes are discarded.
  - 001xxxxx: function set; DL=1 returns to MODE8 with four_bit=0.
  - 0001xxxx: shift; ignored.
  - 00001xxx: disp_on=byte[2].
  - 000001xx: increment=byte[1].
  - 0000001x: addr=0, busy=BUSY_CLR.
  - 00000001: rows filled with spaces, addr=0, increment=1, busy=BUSY_CLR, update pulses.
- Data write (RS=1, not CGRAM):
  - addr 0x00–0x0F writes row_a column addr.
  - addr 0x40–0x4F writes row_b column addr-0x40.
  - Any other addr: write discarded, no update pulse.
  - After every data write, addr steps by ±1.
- Address wrap:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
  - Addresses 0x28–0x3F and 0x68–0x7F are legal only via a set-address command and continue stepping ±1 modulo 128.
- Busy: every executed write loads BUSY_CMD into the counter (or BUSY_CLR as listed above). The counter decrements to 0. A write completed while the counter is non-zero sets err (sticky until reset); the write is still executed.
- Reset mid-byte: a captured high nibble is dropped and the state returns to MODE8.
- Simultaneous events: the reset edge dominates everything. Only one E fall can be detected per cycle.

Decomposition:
- Package lcd_rx_pkg:
  - state enum: MODE8, MODE4_HI, MODE4_LO
  - ASCII_SPACE = 8'h20
  - DDRAM bounds: 0x00, 0x0F, 0x27, 0x40, 0x4F, 0x67
  - command-class decode masks
- Sub-module lcd_bus_sampler: 2-flop synchronisers plus registered E falling-edge strobe. Outputs fall_stb, rs_s, rw_s, d_s.

Test Plan:
1. Init: nibbles 3,3,3,2 (RS=0), then 0x28, 0x06, 0x0C, 0x01 with ≥BUSY gaps → four_bit=1, disp_on=1, rows all 8'h20, err=0.
2. 0x80 then "Fibo #01 is 0000" → row_a equals that string, update pulses 16 times; 0xC0 then "Fibo #02 is 0001" → row_b equals that string.
3. 0x8F, 'X', 'Y' → row_a col15='X'; 'Y' goes to 0x10 and is discarded, rows otherwise unchanged.
4. 0xA7, 'Z', 'Q' → 'Z' discarded, addr wraps to 0x40, row_b col0='Q'.
5. 0x04, 0x80, 'A', 'B' → row_a col0='A'; addr wraps 0x00→0x67 and 'B' is discarded.
6. 0x01 then a data write 100 cycles later → err=1 and the write is still applied. Reset after a lone high nibble → rows all spaces, four_bit=0, next pulse decoded as MODE8.

Source files
------------

// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the HD44780-style LCD bus receiver.
// Holds the state encoding, DDRAM address bounds and command-class decode.
package lcd_rx_pkg;

  typedef enum logic [1:0] {
    MODE8    = 2'd0,
    MODE4_HI = 2'd1,
    MODE4_LO = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISP,
    CMD_SHIFT,
    CMD_FUNC,
    CMD_CGRAM,
    CMD_DDRAM
  } cmd_e;

  localparam int CNT_W = 18;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [6:0] ROW_A_FIRST = 7'h00;
  localparam logic [6:0] ROW_A_LAST  = 7'h0F;
  localparam logic [6:0] LINE0_END   = 7'h27;
  localparam logic [6:0] ROW_B_FIRST = 7'h40;
  localparam logic [6:0] ROW_B_LAST  = 7'h4F;
  localparam logic [6:0] LINE1_END   = 7'h67;

  localparam logic [7:0] MASK_DDRAM = 8'h80;
  localparam logic [7:0] MASK_CGRAM = 8'h40;
  localparam logic [7:0] MASK_FUNC  = 8'h20;
  localparam logic [7:0] MASK_SHIFT = 8'h10;
  localparam logic [7:0] MASK_DISP  = 8'h08;
  localparam logic [7:0] MASK_ENTRY = 8'h04;
  localparam logic [7:0] MASK_HOME  = 8'h02;
  localparam logic [7:0] MASK_CLEAR = 8'h01;

  // Highest set bit selects the command class.
  function automatic cmd_e decode_cmd(logic [7:0] b);
    cmd_e c;
    if      ((b & MASK_DDRAM) != 8'h00) c = CMD_DDRAM;
    else if ((b & MASK_CGRAM) != 8'h00) c = CMD_CGRAM;
    else if ((b & MASK_FUNC)  != 8'h00) c = CMD_FUNC;
    else if ((b & MASK_SHIFT) != 8'h00) c = CMD_SHIFT;
    else if ((b & MASK_DISP)  != 8'h00) c = CMD_DISP;
    else if ((b & MASK_ENTRY) != 8'h00) c = CMD_ENTRY;
    else if ((b & MASK_HOME)  != 8'h00) c = CMD_HOME;
    else if ((b & MASK_CLEAR) != 8'h00) c = CMD_CLEAR;
    else                                c = CMD_NONE;
    return c;
  endfunction

  // Line ends wrap to the start of the other line; everything else is modulo 128.
  function automatic logic [6:0] step_addr(logic [6:0] a, logic inc);
    logic [6:0] n;
    if (inc) begin
      if      (a == LINE0_END) n = ROW_B_FIRST;
      else if (a == LINE1_END) n = ROW_A_FIRST;
      else                     n = a + 7'd1;
    end else begin
      if      (a == ROW_A_FIRST) n = LINE1_END;
      else if (a == ROW_B_FIRST) n = LINE0_END;
      else                       n = a - 7'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lcd_rx_monitor_sampler.sv
// Synchronises the asynchronous LCD bus and emits a registered strobe per E fall,
// carrying RS/RW/D as they were while the synchronised E was still high.
module lcd_bus_sampler (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_d,
  output logic       fall_stb,
  output logic       rs_s,
  output logic       rw_s,
  output logic [3:0] d_s
);

  // Bit 6 = E, bit 5 = RS, bit 4 = RW, bits 3:0 = D.
  logic [6:0] s1_q, s2_q, prev_q;
  logic       stb_q, rs_q, rw_q;
  logic [3:0] d_q;
  logic       fall;

  assign fall = prev_q[6] & ~s2_q[6];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      stb_q  <= 1'b0;
      rs_q   <= 1'b0;
      rw_q   <= 1'b0;
      d_q    <= 4'h0;
    end else begin
      s1_q   <= {lcd_e, lcd_rs, lcd_rw, lcd_d};
      s2_q   <= s1_q;
      prev_q <= s2_q;
      stb_q  <= fall;
      if (fall) begin
        rs_q <= prev_q[5];
        rw_q <= prev_q[4];
        d_q  <= prev_q[3:0];
      end
    end
  end

  assign fall_stb = stb_q;
  assign rs_s     = rs_q;
  assign rw_s     = rw_q;
  assign d_s      = d_q;

endmodule

// File: rtl/lcd_rx_monitor.sv
// Receiving-end model of the 4-bit HD44780 LCD bus: decodes writes and keeps a
// shadow image of the two visible 16-char rows. States: MODE8 = 8-bit init phase,
// MODE4_HI = awaiting high nibble, MODE4_LO = awaiting low nibble (byte executes).
module lcd_rx_monitor
  import lcd_rx_pkg::*;
#(
  parameter int BUSY_CMD = 4000,
  parameter int BUSY_CLR = 164000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         lcd_e,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic [3:0]   lcd_d,
  output logic [127:0] row_a,
  output logic [127:0] row_b,
  output logic         disp_on,
  output logic         update,
  output logic         err,
  output logic         four_bit
);

  logic       fall_stb, rs_s, rw_s;
  logic [3:0] d_s;

  lcd_bus_sampler u_sampler (
    .clk      (clk),
    .reset_n  (reset_n),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_d    (lcd_d),
    .fall_stb (fall_stb),
    .rs_s     (rs_s),
    .rw_s     (rw_s),
    .d_s      (d_s)
  );

  state_e             state_q, state_d;
  logic [127:0]       row_a_q, row_a_d, row_b_q, row_b_d;
  logic [6:0]         addr_q, addr_d;
  logic [3:0]         hi_q, hi_d;
  logic [CNT_W-1:0]   busy_q, busy_d;
  logic               inc_q, inc_d, cgram_q, cgram_d;
  logic               disp_q, disp_d, upd_q, upd_d, err_q, err_d, fourb_q, fourb_d;
  logic [7:0]         wr_byte;

  always_comb begin
    state_d = state_q;
    row_a_d = row_a_q;
    row_b_d = row_b_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    inc_d   = inc_q;
    cgram_d = cgram_q;
    disp_d  = disp_q;
    err_d   = err_q;
    fourb_d = fourb_q;
    upd_d   = 1'b0;
    busy_d  = (busy_q == '0) ? '0 : busy_q - 1'b1;
    wr_byte = (state_q == MODE8) ? {d_s, 4'h0} : {hi_q, d_s};

    if (fall_stb) begin
      case (state_q)
        MODE4_HI: begin
          hi_d    = d_s;
          state_d = MODE4_LO;
        end
        MODE8, MODE4_LO: begin
          if (state_q == MODE4_LO) state_d = MODE4_HI;
          if (!rw_s) begin
            if (busy_q != '0) err_d = 1'b1;
            busy_d = CNT_W'(BUSY_CMD);
            if (rs_s) begin
              if (!cgram_q) begin
                for (int i = 0; i < 16; i++) begin
                  if (addr_q == (ROW_A_FIRST + 7'(i))) begin
                    row_a_d[127-8*i -: 8] = wr_byte;
                    upd_d = 1'b1;
                  end
                  if (addr_q == (ROW_B_FIRST + 7'(i))) begin
                    row_b_d[127-8*i -: 8] = wr_byte;
                    upd_d = 1'b1;
                  end
                end
                addr_d = step_addr(addr_q, inc_q);
              end
            end else begin
              case (decode_cmd(wr_byte))
                CMD_DDRAM: begin
                  addr_d  = wr_byte[6:0];
                  cgram_d = 1'b0;
                end
                CMD_CGRAM: cgram_d = 1'b1;
                CMD_FUNC: begin
                  state_d = wr_byte[4] ? MODE8 : MODE4_HI;
                  fourb_d = ~wr_byte[4];
                end
                CMD_DISP:  disp_d = wr_byte[2];
                CMD_ENTRY: inc_d  = wr_byte[1];
                CMD_HOME: begin
                  addr_d = 7'h00;
                  busy_d = CNT_W'(BUSY_CLR);
                end
                CMD_CLEAR: begin
                  row_a_d = {16{ASCII_SPACE}};
                  row_b_d = {16{ASCII_SPACE}};
                  addr_d  = 7'h00;
                  inc_d   = 1'b1;
                  busy_d  = CNT_W'(BUSY_CLR);
                  upd_d   = 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        default: state_d = MODE8;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MODE8;
      row_a_q <= {16{ASCII_SPACE}};
      row_b_q <= {16{ASCII_SPACE}};
      addr_q  <= 7'h00;
      hi_q    <= 4'h0;
      busy_q  <= '0;
      inc_q   <= 1'b1;
      cgram_q <= 1'b0;
      disp_q  <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      fourb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_a_q <= row_a_d;
      row_b_q <= row_b_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      inc_q   <= inc_d;
      cgram_q <= cgram_d;
      disp_q  <= disp_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      fourb_q <= fourb_d;
    end
  end

  assign row_a    = row_a_q;
  assign row_b    = row_b_q;
  assign disp_on  = disp_q;
  assign update   = upd_q;
  assign err      = err_q;
  assign four_bit = fourb_q;

endmodule
